// File: rtl/instr_loader.sv
// Byte-stream instruction loader: packs big-endian words into instruction memory, then releases CPU reset.
// Optional end-of-stream XOR checksum byte is enabled by defining INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
   parameter int DEPTH = 256
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [15:0] len_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic        byte_ready_o,
   output logic        im_we_o,
   output logic [31:0] im_addr_o,
   output logic [31:0] im_data_o,
   output logic        cpu_rst_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_CHECK = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;

   localparam logic [31:0] L_DEPTH = 32'(DEPTH);

   logic [2:0]  r_state;
   logic [1:0]  r_byte_cnt;
   logic [15:0] r_word_cnt;
   logic [15:0] r_len;
   logic [23:0] r_asm;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_data;
`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [7:0]  r_xor;
`endif

   logic [15:0] w_len_eff;
   logic        w_xfer;
   logic        w_start_ok;
   logic        w_last_word;

   assign w_len_eff   = ({16'd0, len_i} > L_DEPTH) ? L_DEPTH[15:0] : len_i;
   assign w_xfer      = byte_valid_i & byte_ready_o;
   assign w_last_word = (r_word_cnt + 16'd1) == r_len;

`ifdef INSTR_LOADER_CHECKSUM_EN
   assign w_start_ok   = start_i & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
   assign byte_ready_o = ((r_state == S_LOAD) & (r_len != 16'd0)) | (r_state == S_CHECK);
   assign err_o        = (r_state == S_ERR);
`else
   assign w_start_ok   = start_i & ((r_state == S_IDLE) | (r_state == S_DONE));
   assign byte_ready_o = (r_state == S_LOAD) & (r_len != 16'd0);
   assign err_o        = 1'b0;
`endif

   assign busy_o    = (r_state == S_LOAD) | (r_state == S_CHECK);
   assign done_o    = (r_state == S_DONE);
   assign cpu_rst_o = (r_state == S_DONE);
   assign im_we_o   = r_we;
   assign im_addr_o = r_addr;
   assign im_data_o = r_data;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state    <= S_IDLE;
         r_byte_cnt <= 2'd0;
         r_word_cnt <= 16'd0;
         r_len      <= 16'd0;
         r_asm      <= 24'd0;
         r_we       <= 1'b0;
         r_addr     <= 32'd0;
         r_data     <= 32'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
         r_xor      <= 8'd0;
`endif
      end else begin
         r_we <= 1'b0;
         if (w_start_ok) begin
            r_state    <= S_LOAD;
            r_byte_cnt <= 2'd0;
            r_word_cnt <= 16'd0;
            r_len      <= w_len_eff;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_xor      <= 8'd0;
`endif
         end else begin
            case (r_state)
               S_LOAD: begin
                  if (r_len == 16'd0) begin
                     r_state <= S_DONE;
                  end else if (w_xfer) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                     r_xor <= r_xor ^ byte_data_i;
`endif
                     r_byte_cnt <= r_byte_cnt + 2'd1;
                     if (r_byte_cnt == 2'd3) begin
                        // Output word register is separate so assembly continues during the write cycle.
                        r_we       <= 1'b1;
                        r_addr     <= {14'd0, r_word_cnt, 2'b00};
                        r_data     <= {r_asm, byte_data_i};
                        r_word_cnt <= r_word_cnt + 16'd1;
                        if (w_last_word) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                           r_state <= S_CHECK;
`else
                           r_state <= S_DONE;
`endif
                        end
                     end else begin
                        r_asm <= {r_asm[15:0], byte_data_i};
                     end
                  end
               end
`ifdef INSTR_LOADER_CHECKSUM_EN
               S_CHECK: begin
                  if (w_xfer) begin
                     r_state <= (byte_data_i == r_xor) ? S_DONE : S_ERR;
                  end
               end
               S_ERR: r_state <= S_ERR;
`endif
               S_IDLE: r_state <= S_IDLE;
               S_DONE: r_state <= S_DONE;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with a write scoreboard; define INSTR_LOADER_CHECKSUM_EN to exercise the checksum path.
module tb_instr_loader;
   localparam int DEPTH = 16;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        start_i = 1'b0;
   logic [15:0] len_i = 16'd0;
   logic        byte_valid_i = 1'b0;
   logic [7:0]  byte_data_i = 8'd0;
   logic        byte_ready_o;
   logic        im_we_o;
   logic [31:0] im_addr_o;
   logic [31:0] im_data_o;
   logic        cpu_rst_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;

   instr_loader #(.DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
      .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
      .im_we_o(im_we_o), .im_addr_o(im_addr_o), .im_data_o(im_data_o),
      .cpu_rst_o(cpu_rst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t  sb[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   n_fail = 0;
   int   n_writes = 0;
   logic prev_we = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   always @(negedge clk_i) begin
      wr_t e;
      if (im_we_o) begin
         n_writes++;
         check("we_one_cycle", {31'd0, prev_we}, 32'd0);
         if (sb.size() == 0) begin
            check("wr_unexpected", {31'd0, im_we_o}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("wr_addr", im_addr_o, e.addr);
            check("wr_data", im_data_o, e.data);
         end
      end
      prev_we = im_we_o;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_load(input logic [15:0] len);
      start_i = 1'b1;
      len_i   = len;
      tick();
      start_i = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int budget;
      budget = 0;
      byte_valid_i = 1'b1;
      byte_data_i  = b;
      while (!byte_ready_o && budget < 50) begin
         tick();
         budget++;
      end
      if (!byte_ready_o) check("ready_timeout", {31'd0, byte_ready_o}, 32'd1);
      tick();
   endtask

   task automatic load_word(input int idx, input logic [31:0] w);
      logic [31:0] a;
      a = idx * 4;
      sb.push_back({a, w});
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          w0;
      logic [31:0] word;
      logic [7:0]  ib;

      // Reset state
      tick();
      tick();
      check("rst_ready", {31'd0, byte_ready_o}, 32'd0);
      check("rst_we", {31'd0, im_we_o}, 32'd0);
      check("rst_addr", im_addr_o, 32'd0);
      check("rst_data", im_data_o, 32'd0);
      check("rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_done", {31'd0, done_o}, 32'd0);
      check("rst_err", {31'd0, err_o}, 32'd0);
      rst_i = 1'b1;
      tick();

      // Two words back-to-back
      start_load(16'd2);
      check("t1_busy", {31'd0, busy_o}, 32'd1);
      check("t1_ready", {31'd0, byte_ready_o}, 32'd1);
      check("t1_cpu_rst_load", {31'd0, cpu_rst_o}, 32'd0);
      load_word(0, 32'h2008_0005);
      load_word(1, 32'h0000_0008);
      byte_valid_i = 1'b0;
      check("t1_done", {31'd0, done_o}, 32'd1);
      check("t1_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
      check("t1_busy_done", {31'd0, busy_o}, 32'd0);
      check("t1_err", {31'd0, err_o}, 32'd0);
      tick();
      check("t1_we_low", {31'd0, im_we_o}, 32'd0);
      check("t1_addr_hold", im_addr_o, 32'h4);
      check("t1_data_hold", im_data_o, 32'h8);

      // One word with byte_valid toggling
      w0 = n_writes;
      start_load(16'd1);
      word = 32'hDEAD_BEEF;
      sb.push_back({32'd0, word});
      for (int i = 0; i < 4; i++) begin
         check("t2_busy", {31'd0, busy_o}, 32'd1);
         ib = word[31:24];
         word = {word[23:0], 8'd0};
         send_byte(ib);
         byte_valid_i = 1'b0;
         if (i < 3) begin
            check("t2_stall_busy", {31'd0, busy_o}, 32'd1);
            tick();
         end
      end
      check("t2_done", {31'd0, done_o}, 32'd1);
      tick();
      check("t2_write_count", n_writes - w0, 32'd1);

      // Zero length
      w0 = n_writes;
      start_load(16'd0);
      check("t3_not_done_yet", {31'd0, done_o}, 32'd0);
      check("t3_busy", {31'd0, busy_o}, 32'd1);
      tick();
      check("t3_done", {31'd0, done_o}, 32'd1);
      check("t3_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
      tick();
      check("t3_no_writes", n_writes - w0, 32'd0);

      // Length above DEPTH is clamped
      w0 = n_writes;
      start_load(16'(DEPTH + 5));
      for (int i = 0; i < DEPTH; i++) begin
         ib = i[7:0];
         load_word(i, {ib, 8'hA5, ~ib, 8'h5A});
      end
      byte_valid_i = 1'b0;
      check("t4_done", {31'd0, done_o}, 32'd1);
      check("t4_ready_done", {31'd0, byte_ready_o}, 32'd0);
      byte_valid_i = 1'b1;
      tick();
      tick();
      byte_valid_i = 1'b0;
      check("t4_write_count", n_writes - w0, 32'(DEPTH));
      check("t4_last_addr", im_addr_o, 32'((DEPTH - 1) * 4));

      // Reset mid-word, then fresh load
      start_load(16'd1);
      send_byte(8'h11);
      send_byte(8'h22);
      rst_i = 1'b0;
      #1;
      check("t5_rst_busy", {31'd0, busy_o}, 32'd0);
      check("t5_rst_ready", {31'd0, byte_ready_o}, 32'd0);
      check("t5_rst_addr", im_addr_o, 32'd0);
      check("t5_rst_data", im_data_o, 32'd0);
      tick();
      rst_i = 1'b1;
      byte_data_i = 8'h77;
      tick();
      tick();
      tick();
      check("t5_no_restart", {31'd0, busy_o}, 32'd0);
      check("t5_idle_ready", {31'd0, byte_ready_o}, 32'd0);
      byte_valid_i = 1'b0;
      start_load(16'd1);
      load_word(0, 32'h3344_5566);
      byte_valid_i = 1'b0;
      check("t5_done", {31'd0, done_o}, 32'd1);
      tick();

`ifdef INSTR_LOADER_CHECKSUM_EN
      // Bad checksum then good checksum
      start_load(16'd1);
      load_word(0, 32'h0102_0304);
      byte_valid_i = 1'b0;
      check("t6_check_busy", {31'd0, busy_o}, 32'd1);
      check("t6_check_ready", {31'd0, byte_ready_o}, 32'd1);
      check("t6_check_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
      send_byte(8'h05);
      byte_valid_i = 1'b0;
      check("t6_err", {31'd0, err_o}, 32'd1);
      check("t6_err_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
      check("t6_err_done", {31'd0, done_o}, 32'd0);
      start_load(16'd1);
      check("t6_err_cleared", {31'd0, err_o}, 32'd0);
      load_word(0, 32'h0102_0304);
      send_byte(8'h04);
      byte_valid_i = 1'b0;
      check("t6_good_done", {31'd0, done_o}, 32'd1);
      check("t6_good_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
      check("t6_good_err", {31'd0, err_o}, 32'd0);
      tick();
`else
      check("t6_err_tied", {31'd0, err_o}, 32'd0);
`endif

      tick();
      check("sb_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning instruction-memory capacity in 32-bit words.
REQ-002 SHALL have port clk_i  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start_i  input  1  pulse that begins a load; sampled only in IDLE or DONE.
REQ-005 SHALL have port len_i  input  16  number of words to load; sampled in the start cycle.
REQ-006 SHALL have port byte_valid_i  input  1  byte stream valid.
REQ-007 SHALL have port byte_data_i  input  8  byte stream data.
REQ-008 SHALL have port byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port im_we_o  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 SHALL have port im_addr_o  output  32  instruction-memory byte address of the word being written.
REQ-011 SHALL have port im_data_o  output  32  instruction word being written.
REQ-012 SHALL have port cpu_rst_o  output  1  active-low reset to the CPU; low holds the CPU in reset.
REQ-013 SHALL have port busy_o  output  1  high while in LOAD or CHECK.
REQ-014 SHALL have port done_o  output  1  high while in DONE.
REQ-015 SHALL have port err_o  output  1  checksum mismatch flag; tied 0 when INSTR_LOADER_CHECKSUM_EN is undefined.

Function
REQ-016 SHALL implement the FSM states IDLE, LOAD, CHECK, DONE and ERR.
REQ-017 SHALL move IDLE->LOAD, or DONE->LOAD, in the cycle after start_i=1 and clear the byte and word counters.
REQ-018 SHALL use effective length min(len_i, DEPTH); with effective length 0 it SHALL go LOAD->DONE on the next cycle with no writes.
REQ-019 SHALL hold byte_ready_o=1 only in LOAD, or in CHECK while awaiting the checksum byte; a byte transfers when byte_valid_i & byte_ready_o.
REQ-020 SHALL assemble words big-endian: the first byte of each group of four goes to [31:24], the fourth to [7:0].
REQ-021 SHALL assert im_we_o for exactly one cycle, the cycle after the fourth byte transfers, with im_addr_o = word_index*4 (index from 0) and im_data_o = the assembled word.
REQ-022 SHALL keep accepting bytes during the im_we_o cycle without stalling (the assembly register is separate from the im_data_o register).
REQ-023 SHALL, after the last word's fourth byte, go to DONE, or to CHECK when checksum is enabled; the last im_we_o pulse coincides with the first DONE/CHECK cycle.
REQ-024 SHALL treat byte_valid_i=0 cycles as stalls with no state change.
REQ-025 SHALL ignore start_i while in LOAD or CHECK.
REQ-026 SHALL drive cpu_rst_o=1 only in DONE; in every other state cpu_rst_o=0.
REQ-027 SHALL hold im_addr_o and im_data_o at their last written values when im_we_o=0.
REQ-028 SHALL wrap the word counter at 16 bits; the DEPTH clamp keeps it from overflowing.

Reset
REQ-029 SHALL, while rst_i=0, force: state=IDLE, counters=0, byte_ready_o=0, im_we_o=0, im_addr_o=0, im_data_o=0, cpu_rst_o=0, busy_o=0, done_o=0, err_o=0.
REQ-030 SHALL discard a partially loaded word on reset mid-load, and SHALL not restart until a new start_i.

Configuration
REQ-031 SHALL, with INSTR_LOADER_CHECKSUM_EN defined, keep a running XOR of all payload bytes and accept one extra byte in CHECK.
REQ-032 SHALL, in CHECK, go to DONE if the extra byte equals the running XOR, otherwise to ERR.
REQ-033 SHALL, in ERR, hold err_o=1 and cpu_rst_o=0; start_i in ERR restarts LOAD and clears err_o.
REQ-034 SHALL, without INSTR_LOADER_CHECKSUM_EN, omit CHECK and ERR, go directly from LOAD to DONE, and tie err_o to 0.

Verification
REQ-035 SHALL cover: start_i with len_i=2 and bytes 20 08 00 05 00 00 00 08 streamed back-to-back -> im_we_o pulses with (addr 0x0, data 0x20080005) then (addr 0x4, data 0x00000008); DONE; cpu_rst_o=1.
REQ-036 SHALL cover: len_i=1 with byte_valid_i toggling every other cycle -> one write of the correct word; busy_o=1 throughout the load.
REQ-037 SHALL cover: len_i=0 -> DONE two cycles after start_i, with no im_we_o.
REQ-038 SHALL cover: len_i=DEPTH+5 -> exactly DEPTH writes; last im_addr_o = (DEPTH-1)*4.
REQ-039 SHALL cover: rst_i=0 after byte 2 of word 1, then start_i with len_i=1 -> the single write is at addr 0 with only the new bytes.
REQ-040 SHALL cover, with checksum enabled: payload 01 02 03 04 followed by checksum 0x05 -> err_o=1 and cpu_rst_o=0; the same payload followed by 0x04 -> DONE.
